// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock parameterised FIFO.
//   fifo_mode_t            : read-side behaviour selector (standard / FWFT)
//   FIFO_DEFAULT_AE_MARGIN : default almost-empty threshold
//   count_width()          : bits needed to hold an occupancy of 0..depth
package fifo_pkg;

  typedef enum logic {FIFO_MODE_STANDARD, FIFO_MODE_FWFT} fifo_mode_t;

  localparam int FIFO_DEFAULT_AE_MARGIN = 4;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-DEPTH pointer for the FIFO storage array.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset, value -> 0
//   clear     : synchronous clear (flush), value -> 0
//   increment : advance by one, wrapping DEPTH-1 -> 0
//   value     : current pointer
module wrap_counter #(
  parameter int DEPTH = 5,
  parameter int WIDTH = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             increment,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      value <= '0;
    end else if (increment) begin
      // Explicit wrap so non-power-of-2 depths never address past the array.
      value <= (value == LAST) ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, FWFT or registered-read mode,
// programmable almost-full/almost-empty thresholds and synchronous flush.
// Optional feature macro: SYNC_FIFO_ERROR_FLAGS_EN (sticky overflow/underflow
// detection; when undefined both ports are tied low).
// Ports:
//   clock, reset                  : clock, synchronous active-high reset
//   flush                         : synchronous clear of pointers and count
//   data_in_enable, data_in       : write strobe / write data
//   data_in_ready                 : not full
//   data_out_acknowledge          : FWFT pop / standard read request
//   data_out, data_out_valid      : read data and its qualifier
//   used                          : occupancy 0..DEPTH
//   almost_full, almost_empty     : threshold flags on used
//   overflow, underflow           : sticky error flags
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH             = 24,
  parameter int DEPTH                  = 512,
  parameter int FWFT                   = 1,
  parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 4,
  parameter int ALMOST_EMPTY_THRESHOLD = FIFO_DEFAULT_AE_MARGIN,
  localparam int COUNT_WIDTH           = count_width(DEPTH),
  localparam int POINTER_WIDTH         = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   data_in_enable,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   data_in_ready,
  input  logic                   data_out_acknowledge,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_out_valid,
  output logic [COUNT_WIDTH-1:0] used,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam fifo_mode_t MODE = (FWFT != 0) ? FIFO_MODE_FWFT : FIFO_MODE_STANDARD;
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);
  // A negative almost-full threshold (small DEPTH with the default) means "always".
  localparam logic [COUNT_WIDTH-1:0] AF_LEVEL =
    (ALMOST_FULL_THRESHOLD < 0) ? '0 : COUNT_WIDTH'(ALMOST_FULL_THRESHOLD);
  localparam logic [COUNT_WIDTH-1:0] AE_LEVEL = COUNT_WIDTH'(ALMOST_EMPTY_THRESHOLD);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be >= 2");
  end
  if (ALMOST_FULL_THRESHOLD > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: ALMOST_FULL_THRESHOLD must be <= DEPTH");
  end
  if (ALMOST_EMPTY_THRESHOLD >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_param: ALMOST_EMPTY_THRESHOLD must be < DEPTH");
  end

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [COUNT_WIDTH-1:0]   used_q;
  logic [POINTER_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                     full, empty, wr_fire, rd_fire;
  logic [DATA_WIDTH-1:0]    head;

  assign full          = (used_q == FULL_COUNT);
  assign empty         = (used_q == '0);
  // Ready comes from the registered count only: a same-cycle pop never frees
  // a slot for a write when full.
  assign data_in_ready = !full;
  // Flush (and reset) swallow any same-cycle write or pop.
  assign wr_fire       = data_in_enable && !full && !flush && !reset;
  assign rd_fire       = data_out_acknowledge && !empty && !flush && !reset;

  wrap_counter #(.DEPTH(DEPTH), .WIDTH(POINTER_WIDTH)) u_wr_ptr (
    .clock(clock), .reset(reset), .clear(flush), .increment(wr_fire), .value(wr_ptr)
  );
  wrap_counter #(.DEPTH(DEPTH), .WIDTH(POINTER_WIDTH)) u_rd_ptr (
    .clock(clock), .reset(reset), .clear(flush), .increment(rd_fire), .value(rd_ptr)
  );

  always_ff @(posedge clock) begin
    if (wr_fire) mem[wr_ptr] <= data_in;
  end

  assign head = mem[rd_ptr];

  // Explicit occupancy so every slot is usable at any depth.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      used_q <= '0;
    end else if (wr_fire && !rd_fire) begin
      used_q <= used_q + 1'b1;
    end else if (rd_fire && !wr_fire) begin
      used_q <= used_q - 1'b1;
    end
  end

  assign used         = used_q;
  assign almost_full  = (used_q >= AF_LEVEL);
  assign almost_empty = (used_q <= AE_LEVEL);

  if (MODE == FIFO_MODE_FWFT) begin : g_fwft
    assign data_out       = head;
    assign data_out_valid = !empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    // data_out holds its last value; valid is a one-cycle pulse per request.
    always_ff @(posedge clock) begin
      if (reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_fire;
        if (rd_fire) data_q <= head;
      end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
  end

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky until reset; flush deliberately leaves them alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (data_in_enable && full)        overflow_q  <= 1'b1;
      if (data_out_acknowledge && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: two DEPTH=5, 8-bit instances (FWFT and standard mode).
// Directed stimulus pushes expected read data into per-instance queues; a
// negedge monitor pops and compares whenever a word is delivered.
module tb_sync_fifo_param;

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
  localparam logic EXP_FLAG = 1'b1;
`else
  localparam logic EXP_FLAG = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst = 1'b1;
  // FWFT instance
  logic       fw_flush = 0, fw_we = 0, fw_ack = 0;
  logic [7:0] fw_din = 0, fw_dout;
  logic       fw_ready, fw_valid, fw_af, fw_ae, fw_ovf, fw_unf;
  logic [2:0] fw_used;
  // standard instance
  logic       st_flush = 0, st_we = 0, st_ack = 0;
  logic [7:0] st_din = 0, st_dout;
  logic       st_ready, st_valid, st_af, st_ae, st_ovf, st_unf;
  logic [2:0] st_used;

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1)) u_fw (
    .clock(clock), .reset(rst), .flush(fw_flush),
    .data_in_enable(fw_we), .data_in(fw_din), .data_in_ready(fw_ready),
    .data_out_acknowledge(fw_ack), .data_out(fw_dout), .data_out_valid(fw_valid),
    .used(fw_used), .almost_full(fw_af), .almost_empty(fw_ae),
    .overflow(fw_ovf), .underflow(fw_unf)
  );

  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_st (
    .clock(clock), .reset(rst), .flush(st_flush),
    .data_in_enable(st_we), .data_in(st_din), .data_in_ready(st_ready),
    .data_out_acknowledge(st_ack), .data_out(st_dout), .data_out_valid(st_valid),
    .used(st_used), .almost_full(st_af), .almost_empty(st_ae),
    .overflow(st_ovf), .underflow(st_unf)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_fw[$];
  logic [7:0] exp_st[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset();
    chk("fw_rst_used", 32'(fw_used), 0);   chk("fw_rst_ready", 32'(fw_ready), 1);
    chk("fw_rst_valid", 32'(fw_valid), 0); chk("fw_rst_ae", 32'(fw_ae), 1);
    chk("fw_rst_af", 32'(fw_af), 0);       chk("fw_rst_ovf", 32'(fw_ovf), 0);
    chk("fw_rst_unf", 32'(fw_unf), 0);
    chk("st_rst_used", 32'(st_used), 0);   chk("st_rst_ready", 32'(st_ready), 1);
    chk("st_rst_valid", 32'(st_valid), 0); chk("st_rst_dout", 32'(st_dout), 0);
    chk("st_rst_ae", 32'(st_ae), 1);       chk("st_rst_af", 32'(st_af), 0);
    chk("st_rst_ovf", 32'(st_ovf), 0);     chk("st_rst_unf", 32'(st_unf), 0);
  endtask

  // Monitor: FWFT word consumed when valid && ack; standard word on each valid pulse.
  always @(negedge clock) begin
    if (!rst) begin
      if (fw_valid && fw_ack && !fw_flush) begin
        if (exp_fw.size() == 0) chk("fw_unexpected_word", 32'(fw_dout), 32'hFFFF_FFFF);
        else chk("fw_data", 32'(fw_dout), 32'(exp_fw.pop_front()));
      end
      if (st_valid) begin
        if (exp_st.size() == 0) chk("st_unexpected_word", 32'(st_dout), 32'hFFFF_FFFF);
        else chk("st_data", 32'(st_dout), 32'(exp_st.pop_front()));
      end
    end
  end

  initial begin
    tick(); tick();
    check_reset();
    rst = 1'b0;

    // ---- FWFT fill to full, then overflow attempt ----
    for (int i = 0; i < 5; i++) begin
      fw_we = 1; fw_din = 8'((i + 1) * 8'h11); exp_fw.push_back(fw_din);
      tick();
      if (i == 0) begin
        chk("fw_first_valid", 32'(fw_valid), 1); chk("fw_first_data", 32'(fw_dout), 32'h11);
        chk("fw_af_at1", 32'(fw_af), 1);         chk("fw_ae_at1", 32'(fw_ae), 1);
      end
      if (i == 3) chk("fw_ae_at4", 32'(fw_ae), 1);
    end
    chk("fw_full_used", 32'(fw_used), 5); chk("fw_full_ready", 32'(fw_ready), 0);
    chk("fw_full_af", 32'(fw_af), 1);     chk("fw_full_ae", 32'(fw_ae), 0);
    fw_din = 8'h66; tick(); fw_we = 0;
    chk("fw_ovf_used", 32'(fw_used), 5); chk("fw_ovf_flag", 32'(fw_ovf), 32'(EXP_FLAG));

    // ---- drain all five (monitor checks 11..55), refill across the wrap ----
    fw_ack = 1; repeat (5) tick(); fw_ack = 0;
    chk("fw_drained_used", 32'(fw_used), 0); chk("fw_drained_valid", 32'(fw_valid), 0);
    chk("fw_drained_unf", 32'(fw_unf), 0);
    for (int i = 0; i < 3; i++) begin
      fw_we = 1; fw_din = 8'h61 + 8'(i); exp_fw.push_back(fw_din); tick();
    end
    fw_we = 0;
    chk("fw_refill_used", 32'(fw_used), 3);
    fw_ack = 1; tick(); fw_ack = 0;              // pop 0x61 -> used 2
    chk("fw_used2", 32'(fw_used), 2);

    // ---- simultaneous write and pop at used=2 ----
    for (int i = 0; i < 4; i++) begin
      fw_we = 1; fw_ack = 1; fw_din = 8'h71 + 8'(i); exp_fw.push_back(fw_din);
      tick();
      chk("fw_simul_used", 32'(fw_used), 2);
    end
    fw_we = 0;
    repeat (2) tick();                           // pops 0x73, 0x74
    fw_ack = 0;
    chk("fw_empty_again", 32'(fw_used), 0);

    // ---- write + pop into empty: pop ignored, write accepted ----
    fw_we = 1; fw_ack = 1; fw_din = 8'hA0; exp_fw.push_back(8'hA0);
    tick(); fw_we = 0; fw_ack = 0;
    chk("fw_a0_valid", 32'(fw_valid), 1); chk("fw_a0_data", 32'(fw_dout), 32'hA0);
    chk("fw_a0_used", 32'(fw_used), 1);   chk("fw_unf_flag", 32'(fw_unf), 32'(EXP_FLAG));
    fw_ack = 1; tick(); fw_ack = 0;

    // ---- flush at used=3 with a simultaneous write ----
    for (int i = 0; i < 3; i++) begin
      fw_we = 1; fw_din = 8'h31 + 8'(i); tick();
    end
    fw_flush = 1; fw_din = 8'h77; tick(); fw_flush = 0; fw_we = 0;
    chk("fw_flush_used", 32'(fw_used), 0);  chk("fw_flush_valid", 32'(fw_valid), 0);
    chk("fw_flush_ready", 32'(fw_ready), 1);
    chk("fw_flush_ovf", 32'(fw_ovf), 32'(EXP_FLAG)); chk("fw_flush_unf", 32'(fw_unf), 32'(EXP_FLAG));
    fw_we = 1; fw_din = 8'h45; exp_fw.push_back(8'h45); tick(); fw_we = 0;
    chk("fw_post_flush_data", 32'(fw_dout), 32'h45); chk("fw_post_flush_used", 32'(fw_used), 1);
    fw_ack = 1; tick(); fw_ack = 0;

    // ---- standard mode: two writes, three requests ----
    st_we = 1; st_din = 8'h01; exp_st.push_back(8'h01); tick();
    st_din = 8'h02; exp_st.push_back(8'h02); tick(); st_we = 0;
    st_ack = 1;
    tick(); chk("st_req1_valid", 32'(st_valid), 1); chk("st_req1_data", 32'(st_dout), 32'h01);
    tick(); chk("st_req2_valid", 32'(st_valid), 1); chk("st_req2_data", 32'(st_dout), 32'h02);
    tick(); chk("st_req3_valid", 32'(st_valid), 0); chk("st_hold_data", 32'(st_dout), 32'h02);
    st_ack = 0;
    chk("st_unf_flag", 32'(st_unf), 32'(EXP_FLAG)); chk("st_used0", 32'(st_used), 0);
    // request + write while empty: request rejected, write accepted
    st_we = 1; st_ack = 1; st_din = 8'h03; exp_st.push_back(8'h03);
    tick(); st_we = 0; st_ack = 0;
    chk("st_empty_rw_valid", 32'(st_valid), 0); chk("st_empty_rw_used", 32'(st_used), 1);
    st_ack = 1; tick(); st_ack = 0;
    chk("st_req4_data", 32'(st_dout), 32'h03);
    tick();
    chk("st_pulse_end", 32'(st_valid), 0);

    // ---- reset mid-stream ----
    fw_we = 1; fw_din = 8'h51; tick(); fw_din = 8'h52; tick(); fw_we = 0;
    st_we = 1; st_din = 8'h09; tick(); st_we = 0;
    rst = 1; tick(); rst = 0;
    check_reset();
    tick();

    chk("fw_queue_drained", 32'(exp_fw.size()), 0);
    chk("st_queue_drained", 32'(exp_st.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
